// File: rtl/ifmap_read_controller.sv
// ifmap_read_controller: streams convolution-ordered reads from the filled ifmap read bank to the PE array
// Ports: clk/rst_n (sync, active-low); config_* latched by config_en in CONFIG, config_done ends configuration;
// switch = bank-swap pulse; array_ready = PE array accepts a read; ren/raddr = buffer read port;
// rdata_valid = ren delayed one cycle; last_read = final read of the bank; ready_to_switch = bank may be swapped.
module ifmap_read_controller #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int COUNT_WIDTH     = 4,
  parameter int PASS_WIDTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       config_en,
  input  logic [COUNT_WIDTH-1:0]     config_ox0,
  input  logic [COUNT_WIDTH-1:0]     config_oy0,
  input  logic [COUNT_WIDTH-1:0]     config_fx,
  input  logic [COUNT_WIDTH-1:0]     config_fy,
  input  logic [COUNT_WIDTH-1:0]     config_stride,
  input  logic [PASS_WIDTH-1:0]      config_passes,
  input  logic                       config_done,
  input  logic                       switch,
  input  logic                       array_ready,
  output logic                       ren,
  output logic [BANK_ADDR_WIDTH-1:0] raddr,
  output logic                       rdata_valid,
  output logic                       last_read,
  output logic                       ready_to_switch
);
  localparam int CW = COUNT_WIDTH;
  localparam int PW = PASS_WIDTH;
  // wide enough for (oy*stride+fy)*ix0 + ox*stride+fx with every field at its maximum
  localparam int FW = 4 * CW + 3;
  localparam int AW = FW > BANK_ADDR_WIDTH ? FW : BANK_ADDR_WIDTH;
  typedef enum logic [2:0] {RESET, CONFIG, WAIT_SWITCH, READ, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cfg_ox0, cfg_oy0, cfg_fx, cfg_fy, cfg_stride;
  logic [PW-1:0] cfg_passes;
  logic [CW-1:0] cnt_ox, cnt_oy, cnt_fx, cnt_fy;
  logic [PW-1:0] cnt_pass;
  logic ox_max, oy_max, fx_max, fy_max, pass_max;
  logic [AW-1:0] ix0, row, col, full;
  assign ox_max   = cnt_ox == cfg_ox0 - CW'(1);
  assign oy_max   = cnt_oy == cfg_oy0 - CW'(1);
  assign fx_max   = cnt_fx == cfg_fx - CW'(1);
  assign fy_max   = cnt_fy == cfg_fy - CW'(1);
  assign pass_max = cnt_pass == cfg_passes - PW'(1);
  assign ix0  = (AW'(cfg_ox0) - AW'(1)) * AW'(cfg_stride) + AW'(cfg_fx);
  assign row  = AW'(cnt_oy) * AW'(cfg_stride) + AW'(cnt_fy);
  assign col  = AW'(cnt_ox) * AW'(cfg_stride) + AW'(cnt_fx);
  assign full = row * ix0 + col;
  always_comb begin
    state_nx        = state;
    ren             = 1'b0;
    raddr           = '0;
    last_read       = 1'b0;
    ready_to_switch = 1'b0;
    case (state)
      RESET:       state_nx = CONFIG;
      CONFIG:      state_nx = config_done ? WAIT_SWITCH : CONFIG;
      WAIT_SWITCH: begin
        ready_to_switch = 1'b1;
        state_nx        = switch ? READ : WAIT_SWITCH;
      end
      READ: begin
        ren       = array_ready;
        raddr     = full[BANK_ADDR_WIDTH-1:0];
        last_read = array_ready & ox_max & oy_max & fx_max & fy_max & pass_max;
        state_nx  = last_read ? DONE : READ;
      end
      DONE: begin
        ready_to_switch = 1'b1;
        state_nx        = switch ? READ : DONE;
      end
      default:     state_nx = RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RESET;
      rdata_valid <= 1'b0;
      cfg_ox0     <= '0;
      cfg_oy0     <= '0;
      cfg_fx      <= '0;
      cfg_fy      <= '0;
      cfg_stride  <= '0;
      cfg_passes  <= '0;
      cnt_ox      <= '0;
      cnt_oy      <= '0;
      cnt_fx      <= '0;
      cnt_fy      <= '0;
      cnt_pass    <= '0;
    end else begin
      state       <= state_nx;
      rdata_valid <= ren;
      if (state == CONFIG && config_en) begin
        cfg_ox0    <= config_ox0;
        cfg_oy0    <= config_oy0;
        cfg_fx     <= config_fx;
        cfg_fy     <= config_fy;
        cfg_stride <= config_stride;
        cfg_passes <= config_passes;
      end
      if ((state == WAIT_SWITCH || state == DONE) && switch) begin
        cnt_ox   <= '0;
        cnt_oy   <= '0;
        cnt_fx   <= '0;
        cnt_fy   <= '0;
        cnt_pass <= '0;
      end else if (ren) begin
        // ripple-carry through ox -> oy -> fx -> fy -> pass
        cnt_ox <= ox_max ? '0 : cnt_ox + CW'(1);
        if (ox_max) cnt_oy <= oy_max ? '0 : cnt_oy + CW'(1);
        if (ox_max && oy_max) cnt_fx <= fx_max ? '0 : cnt_fx + CW'(1);
        if (ox_max && oy_max && fx_max) cnt_fy <= fy_max ? '0 : cnt_fy + CW'(1);
        if (ox_max && oy_max && fx_max && fy_max) cnt_pass <= pass_max ? '0 : cnt_pass + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_ifmap_read_controller.sv
// tb_ifmap_read_controller: directed vectors and sequences for ifmap_read_controller
module tb_ifmap_read_controller;
  logic clk = 1'b0, rst_n = 1'b0, config_en = 1'b0, config_done = 1'b0, switch = 1'b0, array_ready = 1'b0;
  logic [3:0] config_ox0 = '0, config_oy0 = '0, config_fx = '0, config_fy = '0, config_stride = '0, config_passes = '0;
  logic ren, rdata_valid, last_read, ready_to_switch;
  logic [7:0] raddr;
  int checks = 0, failures = 0;
  int basic_addr [16] = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
  typedef struct {
    logic sw, ar, ren;
    int   raddr;
    logic last, rts, rv;
  } vec_t;
  vec_t tv [8];
  ifmap_read_controller dut (
    .clk(clk), .rst_n(rst_n), .config_en(config_en),
    .config_ox0(config_ox0), .config_oy0(config_oy0), .config_fx(config_fx), .config_fy(config_fy),
    .config_stride(config_stride), .config_passes(config_passes), .config_done(config_done),
    .switch(switch), .array_ready(array_ready), .ren(ren), .raddr(raddr),
    .rdata_valid(rdata_valid), .last_read(last_read), .ready_to_switch(ready_to_switch)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_ren"}, int'(ren), 0);
    chk({tag, "_raddr"}, int'(raddr), 0);
    chk({tag, "_rv"}, int'(rdata_valid), 0);
    chk({tag, "_last"}, int'(last_read), 0);
    chk({tag, "_rts"}, int'(ready_to_switch), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    {config_en, config_done, switch} = '0;
    array_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("config_rts", int'(ready_to_switch), 0);
    chk("config_ren", int'(ren), 0);
    tick();
  endtask
  task automatic cfg(input int ox, input int oy, input int fx, input int fy, input int st, input int ps);
    config_ox0 = 4'(ox);
    config_oy0 = 4'(oy);
    config_fx = 4'(fx);
    config_fy = 4'(fy);
    config_stride = 4'(st);
    config_passes = 4'(ps);
    config_en = 1'b1;
    config_done = 1'b1;
    tick();
    config_en = 1'b0;
    config_done = 1'b0;
    @(negedge clk);
    chk("wait_rts", int'(ready_to_switch), 1);
    chk("wait_ren", int'(ren), 0);
    tick();
  endtask
  task automatic start();
    switch = 1'b1;
    tick();
    switch = 1'b0;
  endtask
  // n reads of the basic 16-address sequence; optional 1,0,0,1 stalls, mid-READ switch, config_en poke
  task automatic sweep(input int n, input bit stall, input bit mid_sw, input bit poke);
    int idx = 0;
    int cyc = 0;
    bit ar;
    while (idx < n && cyc < 1000) begin
      ar = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      array_ready = ar;
      switch = mid_sw && idx == 5;
      config_en = poke;
      if (poke) begin
        config_ox0 = 4'd3;
        config_fx = 4'd1;
        config_stride = 4'd2;
      end
      @(negedge clk);
      chk("sweep_ren", int'(ren), int'(ar));
      chk("sweep_raddr", int'(raddr), basic_addr[idx % 16]);
      chk("sweep_last", int'(last_read), int'(ar && idx == n - 1));
      chk("sweep_rts", int'(ready_to_switch), 0);
      if (ar) idx++;
      tick();
      cyc++;
    end
    {switch, config_en} = '0;
    array_ready = 1'b1;
    if (idx < n) begin
      failures++;
      $display("FAIL sweep_timeout: got %0d reads expected %0d", idx, n);
    end
    @(negedge clk);
    chk("done_rts", int'(ready_to_switch), 1);
    chk("done_ren", int'(ren), 0);
    chk("done_raddr", int'(raddr), 0);
  endtask
  initial begin
    tv[0] = '{1, 1, 0, 0, 0, 1, 0};
    tv[1] = '{0, 1, 1, 0, 0, 0, 0};
    tv[2] = '{0, 1, 1, 2, 0, 0, 1};
    tv[3] = '{0, 0, 0, 6, 0, 0, 1};
    tv[4] = '{0, 1, 1, 6, 0, 0, 0};
    tv[5] = '{0, 1, 1, 8, 1, 0, 1};
    tv[6] = '{0, 1, 0, 0, 0, 1, 1};
    tv[7] = '{0, 1, 0, 0, 0, 1, 0};
    do_reset();
    cfg(2, 2, 1, 1, 2, 1);
    for (int i = 0; i < 8; i++) begin
      switch = tv[i].sw;
      array_ready = tv[i].ar;
      @(negedge clk);
      chk($sformatf("tv%0d_ren", i), int'(ren), int'(tv[i].ren));
      chk($sformatf("tv%0d_raddr", i), int'(raddr), tv[i].raddr);
      chk($sformatf("tv%0d_last", i), int'(last_read), int'(tv[i].last));
      chk($sformatf("tv%0d_rts", i), int'(ready_to_switch), int'(tv[i].rts));
      chk($sformatf("tv%0d_rv", i), int'(rdata_valid), int'(tv[i].rv));
      tick();
    end
    switch = 1'b0;
    do_reset();
    cfg(2, 2, 2, 2, 1, 1);
    start();
    sweep(16, 1'b0, 1'b1, 1'b0);
    do_reset();
    cfg(2, 2, 2, 2, 1, 3);
    start();
    sweep(48, 1'b1, 1'b0, 1'b0);
    switch = 1'b1;
    tick();
    switch = 1'b0;
    sweep(48, 1'b0, 1'b0, 1'b1);
    do_reset();
    cfg(2, 2, 2, 2, 1, 1);
    start();
    array_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("pre_reset_raddr", int'(raddr), basic_addr[i]);
      tick();
    end
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_idle("midread_reset");
    do_reset();
    cfg(2, 2, 2, 2, 1, 1);
    start();
    sweep(16, 1'b0, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
